ahb_lite_mst_arbiter: RTL and testbench

Parametrised N-master to one-slave-port AHB-Lite arbiter and multiplexer with per-master address-phase hold buffers. It sits between the core's bus masters (instruction fetch, load/store, future DMA) and the slave-side decoder. It replaces fixed two-master wiring with a MASTERS-wide, mode-selectable arbiter. It adds burst/lock-aware grant switching and a lossless capture of address phases issued by masters that are not granted.

---
 rtl/ahb_lite_mst_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ahb_lite_mst_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mst_arbiter.sv
// N-master to one-slave AHB-Lite arbiter and multiplexer.
// The grant for the current cycle is computed combinationally from the
// registered owner and the live requests, so a granted master that drives
// its own address adds no latency. A master that presents a transfer while
// it does not hold the grant has that address phase captured in its hold
// buffer. The buffer is replayed once the grant reaches that master.
module ahb_lite_mst_arbiter #(
  parameter int MASTERS    = 2,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MASTERS-1:0]           mst_priority,
  input  logic [MASTERS-1:0]           mst_hsel,
  input  logic [MASTERS*HADDR_SIZE-1:0] mst_haddr,
  input  logic [MASTERS*HDATA_SIZE-1:0] mst_hwdata,
  input  logic [MASTERS-1:0]           mst_hwrite,
  input  logic [MASTERS-1:0]           mst_hmastlock,
  input  logic [MASTERS*3-1:0]         mst_hsize,
  input  logic [MASTERS*3-1:0]         mst_hburst,
  input  logic [MASTERS*4-1:0]         mst_hprot,
  input  logic [MASTERS*2-1:0]         mst_htrans,
  output logic [MASTERS-1:0]           mst_hreadyout,
  output logic [MASTERS-1:0]           mst_hresp,
  output logic [MASTERS*HDATA_SIZE-1:0] mst_hrdata,
  output logic [HADDR_SIZE-1:0]        slv_haddr,
  output logic [HDATA_SIZE-1:0]        slv_hwdata,
  output logic                         slv_hwrite,
  output logic [2:0]                   slv_hsize,
  output logic [2:0]                   slv_hburst,
  output logic [3:0]                   slv_hprot,
  output logic [1:0]                   slv_htrans,
  output logic                         slv_hmastlock,
  input  logic                         slv_hready,
  input  logic                         slv_hresp,
  input  logic [HDATA_SIZE-1:0]        slv_hrdata
);

  localparam int OW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  // One address phase as seen by the slave.
  typedef struct packed {
    logic [HADDR_SIZE-1:0] haddr;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic [1:0]            htrans;
    logic                  hmastlock;
  } ap_t;

  logic [OW-1:0]         r_ap_owner;
  logic [OW-1:0]         r_dp_owner;
  logic                  r_dp_valid;
  logic                  r_hb_valid [MASTERS];
  ap_t                   r_hb_ap    [MASTERS];

  ap_t                   w_live_ap  [MASTERS];
  ap_t                   w_eff_ap   [MASTERS];
  logic [HDATA_SIZE-1:0] w_hwdata   [MASTERS];
  logic [MASTERS-1:0]    w_live_req;
  logic [MASTERS-1:0]    w_req;
  logic [MASTERS-1:0]    w_grant_hit;
  logic [MASTERS-1:0]    w_own_mask;
  logic [OW-1:0]         w_winner;
  logic [OW-1:0]         w_grant;
  logic                  w_switch;
  logic                  w_found;
  logic [1:0]            w_cur_htrans;
  logic                  w_cur_lock;
  ap_t                   w_gnt_ap;

  genvar gi;
  generate
    for (gi = 0; gi < MASTERS; gi++) begin : g_mst
      logic w_capture;
      logic w_clear;
      logic w_dp_hit;

      // An idle-selected master presents IDLE and no lock, so a parked
      // owner that is not selected never leaks a transfer to the slave.
      assign w_live_ap[gi] = '{
        haddr:     mst_haddr[gi*HADDR_SIZE +: HADDR_SIZE],
        hwrite:    mst_hwrite[gi],
        hsize:     mst_hsize[gi*3 +: 3],
        hburst:    mst_hburst[gi*3 +: 3],
        hprot:     mst_hprot[gi*4 +: 4],
        htrans:    mst_hsel[gi] ? mst_htrans[gi*2 +: 2] : HT_IDLE,
        hmastlock: mst_hsel[gi] & mst_hmastlock[gi]
      };
      assign w_hwdata[gi]    = mst_hwdata[gi*HDATA_SIZE +: HDATA_SIZE];
      assign w_live_req[gi]  = mst_hsel[gi] & mst_htrans[gi*2+1];
      assign w_eff_ap[gi]    = r_hb_valid[gi] ? r_hb_ap[gi] : w_live_ap[gi];
      assign w_req[gi]       = w_live_req[gi] | r_hb_valid[gi];
      assign w_grant_hit[gi] = (w_grant == OW'(gi));

      // Capture whenever the master believes its address phase completed
      // but the slave did not take it from the live bus this edge.
      assign w_capture = mst_hreadyout[gi] & w_live_req[gi] & ~(w_grant_hit[gi] & slv_hready);
      assign w_clear   = r_hb_valid[gi] & w_grant_hit[gi] & slv_hready;

      // Hold buffer: capture a displaced address phase, release it once accepted.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_hb_valid[gi] <= 1'b0;
          r_hb_ap[gi]    <= '0;
        end else if (w_clear) begin
          r_hb_valid[gi] <= 1'b0;
        end else if (w_capture) begin
          r_hb_valid[gi] <= 1'b1;
          r_hb_ap[gi]    <= w_live_ap[gi];
        end
      end

      // A pending buffer stalls its master; otherwise only the master in
      // a live data phase sees the slave's ready and response.
      assign w_dp_hit           = r_dp_valid & (r_dp_owner == OW'(gi));
      assign mst_hreadyout[gi]  = r_hb_valid[gi] ? 1'b0 : (w_dp_hit ? slv_hready : 1'b1);
      assign mst_hresp[gi]      = w_dp_hit & slv_hresp;
      assign mst_hrdata[gi*HDATA_SIZE +: HDATA_SIZE] = slv_hrdata;
    end
  endgenerate

  // Switching is only safe between bursts and outside locked sequences.
  assign w_own_mask   = MASTERS'(1) << r_ap_owner;
  assign w_cur_htrans = w_eff_ap[r_ap_owner].htrans;
  assign w_cur_lock   = w_eff_ap[r_ap_owner].hmastlock;
  assign w_switch     = slv_hready
                      & ((w_cur_htrans == HT_IDLE) | (w_cur_htrans == HT_NONSEQ))
                      & ~w_cur_lock
                      & (|(w_req & ~w_own_mask));

  // Winner selection: priority-then-index, or rotating after the last owner.
  always_comb begin
    int w_idx;
    w_winner = r_ap_owner;
    w_found  = 1'b0;
    w_idx    = 0;
    if (ARB_MODE == 0) begin
      for (int k = 0; k < MASTERS; k++) begin
        if (!w_found && w_req[k] && mst_priority[k]) begin
          w_winner = OW'(k);
          w_found  = 1'b1;
        end
      end
      for (int k = 0; k < MASTERS; k++) begin
        if (!w_found && w_req[k]) begin
          w_winner = OW'(k);
          w_found  = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= MASTERS; k++) begin
        w_idx = (int'(r_ap_owner) + k) % MASTERS;
        if (!w_found && w_req[w_idx]) begin
          w_winner = OW'(w_idx);
          w_found  = 1'b1;
        end
      end
    end
  end

  assign w_grant  = w_switch ? w_winner : r_ap_owner;
  assign w_gnt_ap = w_eff_ap[w_grant];

  assign slv_haddr     = w_gnt_ap.haddr;
  assign slv_hwrite    = w_gnt_ap.hwrite;
  assign slv_hsize     = w_gnt_ap.hsize;
  assign slv_hburst    = w_gnt_ap.hburst;
  assign slv_hprot     = w_gnt_ap.hprot;
  assign slv_htrans    = w_gnt_ap.htrans;
  assign slv_hmastlock = w_gnt_ap.hmastlock;
  assign slv_hwdata    = w_hwdata[r_dp_owner];

  // Address and data-phase ownership advance only when the slave is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ap_owner <= '0;
      r_dp_owner <= '0;
      r_dp_valid <= 1'b0;
    end else if (slv_hready) begin
      r_ap_owner <= w_grant;
      r_dp_owner <= w_grant;
      r_dp_valid <= w_gnt_ap.htrans[1];
    end
  end

endmodule

// File: tb/tb_ahb_lite_mst_arbiter.sv
// Directed bench for ahb_lite_mst_arbiter: one fixed-priority and one
// round-robin instance share the master and slave stimulus.
module tb_ahb_lite_mst_arbiter;

  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SQ = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [M-1:0]    pri, hsel, hwrite, hlock;
  logic [M*AW-1:0] haddr;
  logic [M*DW-1:0] hwdata;
  logic [M*3-1:0]  hsize, hburst;
  logic [M*4-1:0]  hprot;
  logic [M*2-1:0]  htrans;
  logic            slv_hready, slv_hresp;
  logic [DW-1:0]   slv_hrdata;

  logic [M-1:0]    fp_hreadyout, fp_hresp, rr_hreadyout, rr_hresp;
  logic [M*DW-1:0] fp_hrdata, rr_hrdata;
  logic [AW-1:0]   fp_haddr, rr_haddr;
  logic [DW-1:0]   fp_hwdata, rr_hwdata;
  logic            fp_hwrite, rr_hwrite, fp_hmastlock, rr_hmastlock;
  logic [2:0]      fp_hsize, rr_hsize, fp_hburst, rr_hburst;
  logic [3:0]      fp_hprot, rr_hprot;
  logic [1:0]      fp_htrans, rr_htrans;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahb_lite_mst_arbiter #(.MASTERS(M), .HADDR_SIZE(AW), .HDATA_SIZE(DW), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .mst_priority(pri), .mst_hsel(hsel), .mst_haddr(haddr),
    .mst_hwdata(hwdata), .mst_hwrite(hwrite), .mst_hmastlock(hlock), .mst_hsize(hsize),
    .mst_hburst(hburst), .mst_hprot(hprot), .mst_htrans(htrans),
    .mst_hreadyout(fp_hreadyout), .mst_hresp(fp_hresp), .mst_hrdata(fp_hrdata),
    .slv_haddr(fp_haddr), .slv_hwdata(fp_hwdata), .slv_hwrite(fp_hwrite), .slv_hsize(fp_hsize),
    .slv_hburst(fp_hburst), .slv_hprot(fp_hprot), .slv_htrans(fp_htrans),
    .slv_hmastlock(fp_hmastlock), .slv_hready(slv_hready), .slv_hresp(slv_hresp),
    .slv_hrdata(slv_hrdata));

  ahb_lite_mst_arbiter #(.MASTERS(M), .HADDR_SIZE(AW), .HDATA_SIZE(DW), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .mst_priority(pri), .mst_hsel(hsel), .mst_haddr(haddr),
    .mst_hwdata(hwdata), .mst_hwrite(hwrite), .mst_hmastlock(hlock), .mst_hsize(hsize),
    .mst_hburst(hburst), .mst_hprot(hprot), .mst_htrans(htrans),
    .mst_hreadyout(rr_hreadyout), .mst_hresp(rr_hresp), .mst_hrdata(rr_hrdata),
    .slv_haddr(rr_haddr), .slv_hwdata(rr_hwdata), .slv_hwrite(rr_hwrite), .slv_hsize(rr_hsize),
    .slv_hburst(rr_hburst), .slv_hprot(rr_hprot), .slv_htrans(rr_htrans),
    .slv_hmastlock(rr_hmastlock), .slv_hready(slv_hready), .slv_hresp(slv_hresp),
    .slv_hrdata(slv_hrdata));

  task automatic drv(input int i, input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                     input logic wr, input logic lk, input logic [2:0] burst);
    hsel[i]           = sel;
    htrans[i*2 +: 2]  = tr;
    haddr[i*AW +: AW] = addr;
    hwrite[i]         = wr;
    hlock[i]          = lk;
    hburst[i*3 +: 3]  = burst;
  endtask

  task automatic idle_all();
    for (int i = 0; i < M; i++) drv(i, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    slv_hready = 1'b1;
    slv_hresp  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (fp_htrans !== IDLE) begin n_fail++; $display("FAIL reset_htrans: got %b want %b", fp_htrans, IDLE); end
    n_checks++; if (fp_hmastlock !== 1'b0) begin n_fail++; $display("FAIL reset_hmastlock: got %b want 0", fp_hmastlock); end
    n_checks++; if (fp_hreadyout !== 4'hF) begin n_fail++; $display("FAIL reset_hreadyout: got %b want 1111", fp_hreadyout); end
    n_checks++; if (fp_hresp !== 4'h0) begin n_fail++; $display("FAIL reset_hresp: got %b want 0000", fp_hresp); end
    n_checks++; if (fp_hrdata !== {4{slv_hrdata}}) begin n_fail++; $display("FAIL reset_hrdata: got %h want %h x4", fp_hrdata, slv_hrdata); end
    n_checks++; if (rr_htrans !== IDLE) begin n_fail++; $display("FAIL reset_rr_htrans: got %b want %b", rr_htrans, IDLE); end
    next_cycle();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    drv(2, 1'b1, NS, 32'h1000_0000, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h1000_0000) begin n_fail++; $display("FAIL single_haddr: got %h want 10000000", fp_haddr); end
    n_checks++; if (fp_htrans !== NS) begin n_fail++; $display("FAIL single_htrans: got %b want 10", fp_htrans); end
    n_checks++; if (fp_hwrite !== 1'b1) begin n_fail++; $display("FAIL single_hwrite: got %b want 1", fp_hwrite); end
    n_checks++; if (fp_hreadyout[2] !== 1'b1) begin n_fail++; $display("FAIL single_rdy_a: got %b want 1", fp_hreadyout[2]); end
    next_cycle();
    drv(2, 1'b1, IDLE, 32'h1000_0000, 1'b0, 1'b0, 3'b000);
    hwdata[2*DW +: DW] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (fp_hwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hwdata: got %h want deadbeef", fp_hwdata); end
    n_checks++; if (fp_hreadyout[2] !== 1'b1) begin n_fail++; $display("FAIL single_rdy_d: got %b want 1", fp_hreadyout[2]); end
    next_cycle();
    idle_all();
    $display("test_single done");
  endtask

  task automatic test_priority();
    do_reset();
    pri = 4'b0010;
    drv(0, 1'b1, NS, 32'h0000_0100, 1'b0, 1'b0, 3'b000);
    drv(1, 1'b1, NS, 32'h0000_0200, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0200) begin n_fail++; $display("FAIL prio_first_haddr: got %h want 00000200", fp_haddr); end
    n_checks++; if (fp_hreadyout[0] !== 1'b1) begin n_fail++; $display("FAIL prio_m0_rdy_c0: got %b want 1", fp_hreadyout[0]); end
    next_cycle();
    drv(0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    drv(1, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    slv_hready = 1'b0;
    @(negedge clk);
    n_checks++; if (fp_hreadyout[1:0] !== 2'b00) begin n_fail++; $display("FAIL prio_rdy_c1: got %b want 00", fp_hreadyout[1:0]); end
    n_checks++; if (fp_htrans !== IDLE) begin n_fail++; $display("FAIL prio_htrans_c1: got %b want 00", fp_htrans); end
    next_cycle();
    slv_hready = 1'b1;
    slv_hrdata = 32'h1111_1111;
    @(negedge clk);
    n_checks++; if (fp_hreadyout[1:0] !== 2'b10) begin n_fail++; $display("FAIL prio_rdy_c2: got %b want 10", fp_hreadyout[1:0]); end
    n_checks++; if (fp_hrdata[1*DW +: DW] !== 32'h1111_1111) begin n_fail++; $display("FAIL prio_m1_hrdata: got %h want 11111111", fp_hrdata[1*DW +: DW]); end
    n_checks++; if (fp_haddr !== 32'h0000_0100 || fp_htrans !== NS) begin n_fail++; $display("FAIL prio_replay: got %h/%b want 00000100/10", fp_haddr, fp_htrans); end
    next_cycle();
    slv_hrdata = 32'h2222_2222;
    @(negedge clk);
    n_checks++; if (fp_hreadyout[0] !== 1'b1) begin n_fail++; $display("FAIL prio_m0_rdy_c3: got %b want 1", fp_hreadyout[0]); end
    n_checks++; if (fp_hrdata[0*DW +: DW] !== 32'h2222_2222) begin n_fail++; $display("FAIL prio_m0_hrdata: got %h want 22222222", fp_hrdata[0*DW +: DW]); end
    n_checks++; if (fp_htrans !== IDLE) begin n_fail++; $display("FAIL prio_htrans_c3: got %b want 00", fp_htrans); end
    next_cycle();
    pri = 4'b0000;
    $display("test_priority done");
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < M; i++) drv(i, 1'b1, NS, 32'h4000_0000 + i, 1'b0, 1'b0, 3'b000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (rr_haddr !== (32'h4000_0000 + exp_g[c]) || rr_htrans !== NS) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got %h/%b want %h/10", c, rr_haddr, rr_htrans, 32'h4000_0000 + exp_g[c]);
      end
      next_cycle();
    end
    idle_all();
    $display("test_round_robin done");
  endtask

  task automatic test_burst();
    do_reset();
    drv(0, 1'b1, NS, 32'h0000_0100, 1'b1, 1'b0, 3'b011);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0100) begin n_fail++; $display("FAIL burst_beat1: got %h want 00000100", fp_haddr); end
    next_cycle();
    drv(0, 1'b1, SQ, 32'h0000_0104, 1'b1, 1'b0, 3'b011);
    drv(1, 1'b1, NS, 32'h0000_0900, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0104 || fp_htrans !== SQ) begin n_fail++; $display("FAIL burst_beat2: got %h/%b want 00000104/11", fp_haddr, fp_htrans); end
    next_cycle();
    drv(0, 1'b1, SQ, 32'h0000_0108, 1'b1, 1'b0, 3'b011);
    drv(1, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0108 || fp_hreadyout[1] !== 1'b0) begin n_fail++; $display("FAIL burst_beat3: got %h/rdy%b want 00000108/rdy0", fp_haddr, fp_hreadyout[1]); end
    next_cycle();
    drv(0, 1'b1, SQ, 32'h0000_010C, 1'b1, 1'b0, 3'b011);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_010C || fp_hreadyout[1] !== 1'b0) begin n_fail++; $display("FAIL burst_beat4: got %h/rdy%b want 0000010c/rdy0", fp_haddr, fp_hreadyout[1]); end
    next_cycle();
    drv(0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0900 || fp_htrans !== NS) begin n_fail++; $display("FAIL burst_m1_grant: got %h/%b want 00000900/10", fp_haddr, fp_htrans); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (fp_hreadyout[1] !== 1'b1 || fp_htrans !== IDLE) begin n_fail++; $display("FAIL burst_m1_done: got rdy%b/%b want rdy1/00", fp_hreadyout[1], fp_htrans); end
    next_cycle();
    $display("test_burst done");
  endtask

  task automatic test_lock();
    do_reset();
    drv(0, 1'b1, NS, 32'h0000_0300, 1'b1, 1'b1, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0300 || fp_hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_first: got %h/lk%b want 00000300/lk1", fp_haddr, fp_hmastlock); end
    next_cycle();
    drv(0, 1'b1, NS, 32'h0000_0304, 1'b1, 1'b1, 3'b000);
    drv(1, 1'b1, NS, 32'h0000_0A00, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0304 || fp_hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_second: got %h/lk%b want 00000304/lk1", fp_haddr, fp_hmastlock); end
    next_cycle();
    drv(0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    drv(1, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0A00 || fp_hmastlock !== 1'b0) begin n_fail++; $display("FAIL lock_release: got %h/lk%b want 00000a00/lk0", fp_haddr, fp_hmastlock); end
    n_checks++; if (fp_hreadyout[1] !== 1'b0) begin n_fail++; $display("FAIL lock_m1_held: got %b want 0", fp_hreadyout[1]); end
    next_cycle();
    $display("test_lock done");
  endtask

  task automatic test_error_then_reset();
    do_reset();
    pri = 4'b0010;
    drv(0, 1'b1, NS, 32'h0000_0500, 1'b0, 1'b0, 3'b000);
    drv(1, 1'b1, NS, 32'h0000_0600, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_haddr !== 32'h0000_0600) begin n_fail++; $display("FAIL err_m1_addr: got %h want 00000600", fp_haddr); end
    next_cycle();
    drv(0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    drv(1, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    slv_hready = 1'b0;
    slv_hresp  = 1'b1;
    @(negedge clk);
    n_checks++; if (fp_hresp !== 4'b0010) begin n_fail++; $display("FAIL err_resp_c1: got %b want 0010", fp_hresp); end
    n_checks++; if (fp_hreadyout[1:0] !== 2'b00) begin n_fail++; $display("FAIL err_rdy_c1: got %b want 00", fp_hreadyout[1:0]); end
    next_cycle();
    slv_hready = 1'b1;
    drv(3, 1'b1, NS, 32'h0000_0700, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    n_checks++; if (fp_hresp !== 4'b0010 || fp_hreadyout[1] !== 1'b1) begin n_fail++; $display("FAIL err_resp_c2: got %b/rdy%b want 0010/rdy1", fp_hresp, fp_hreadyout[1]); end
    n_checks++; if (fp_haddr !== 32'h0000_0500) begin n_fail++; $display("FAIL err_m0_replay: got %h want 00000500", fp_haddr); end
    next_cycle();
    drv(3, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 3'b000);
    slv_hresp = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (fp_hreadyout[3] !== 1'b0) begin n_fail++; $display("FAIL err_m3_buffered: got %b want 0", fp_hreadyout[3]); end
    next_cycle();
    rst = 1'b0;
    slv_hready = 1'b0;
    @(negedge clk);
    n_checks++; if (fp_hreadyout !== 4'hF || fp_hresp !== 4'h0) begin n_fail++; $display("FAIL rst_ready_resp: got %b/%b want 1111/0000", fp_hreadyout, fp_hresp); end
    n_checks++; if (fp_htrans !== IDLE || fp_hmastlock !== 1'b0) begin n_fail++; $display("FAIL rst_htrans_lock: got %b/%b want 00/0", fp_htrans, fp_hmastlock); end
    n_checks++; if (fp_hrdata !== {4{slv_hrdata}}) begin n_fail++; $display("FAIL rst_hrdata: got %h want %h x4", fp_hrdata, slv_hrdata); end
    next_cycle();
    slv_hready = 1'b1;
    pri = 4'b0000;
    $display("test_error_then_reset done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pri        = 4'b0000;
    hsize      = {M{3'b010}};
    hprot      = {M{4'b0011}};
    hwdata     = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    slv_hrdata = 32'hA5A5_0001;
    idle_all();
    rst = 1'b1;
    repeat (2) next_cycle();
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_burst();
    test_lock();
    test_error_then_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
